instruction_fetch_unit: RTL and testbench

//  Fetch/decode front end of the basic computer; sits directly upstream of the 4096x16 synchronous memory.

---
 rtl/instruction_fetch_unit.sv | 157 +++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch/decode front end with optional indirect address resolution
//
// Purpose:
//   Presents PC to a 4096x16 synchronous memory, captures the returned word
//   into IR, optionally resolves an indirect effective address with a second
//   read, and hands the decoded instruction to execute over valid/ready.
//
// Optional feature macro: INDIRECT_RESOLVE_EN
//   defined   - I=1 memory-reference instructions are resolved here
//               (INDIRECT/IWAIT states exist)
//   undefined - EA is always IR[A-1:0]; execute resolves indirection itself
//
// Ports:
//   i_clock           clock, all state changes on posedge
//   i_reset           synchronous active-high reset
//   i_fetch_enable    allow a new fetch to start
//   i_pc_load         redirect pulse from execute
//   i_pc_load_value   new PC on redirect
//   o_mem_address     memory read address (combinational)
//   i_mem_read_data   memory read data, valid the cycle after the address
//   o_instr_valid     decoded instruction available
//   i_instr_ready     execute accepts the instruction
//   o_instr_ir        raw instruction word
//   o_instr_opcode    IR[D-2:D-4]
//   o_instr_i_bit     IR[D-1]
//   o_instr_ea        effective address
//   o_instr_pc        address the instruction was fetched from

module instruction_fetch_unit #(
    parameter int A = 12,
    parameter int D = 16
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_fetch_enable,
    input  logic         i_pc_load,
    input  logic [A-1:0] i_pc_load_value,
    output logic [A-1:0] o_mem_address,
    input  logic [D-1:0] i_mem_read_data,
    output logic         o_instr_valid,
    input  logic         i_instr_ready,
    output logic [D-1:0] o_instr_ir,
    output logic [2:0]   o_instr_opcode,
    output logic         o_instr_i_bit,
    output logic [A-1:0] o_instr_ea,
    output logic [A-1:0] o_instr_pc
);

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_FWAIT    = 3'd1,
        S_DECODE   = 3'd2,
        S_ISSUE    = 3'd3
`ifdef INDIRECT_RESOLVE_EN
        ,
        S_INDIRECT = 3'd4,
        S_IWAIT    = 3'd5
`endif
    } state_t;

    state_t       r_state;
    state_t       w_next_state;
    logic [A-1:0] r_pc;
    logic [D-1:0] r_ir;
    logic [A-1:0] r_ea;
    logic [A-1:0] r_instr_pc;
`ifdef INDIRECT_RESOLVE_EN
    logic [A-1:0] r_ar;
    logic         w_is_indirect;

    // Register/IO instructions (opcode 111) reuse the I bit, so they never go indirect.
    assign w_is_indirect = r_ir[D-1] && (r_ir[D-2:D-4] != 3'b111);
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:  if (i_fetch_enable) w_next_state = S_FWAIT;
            S_FWAIT:  w_next_state = S_DECODE;
`ifdef INDIRECT_RESOLVE_EN
            S_DECODE: w_next_state = w_is_indirect ? S_INDIRECT : S_ISSUE;
            S_INDIRECT: w_next_state = S_IWAIT;
            S_IWAIT:  w_next_state = S_ISSUE;
`else
            S_DECODE: w_next_state = S_ISSUE;
`endif
            S_ISSUE:  if (i_instr_ready) w_next_state = S_FETCH;
            default:  w_next_state = S_FETCH;
        endcase
        // A redirect abandons whatever is in flight, including a read whose data is due now.
        if (i_pc_load) begin
            w_next_state = S_FETCH;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_pc       <= '0;
            r_ir       <= '0;
            r_ea       <= '0;
            r_instr_pc <= '0;
`ifdef INDIRECT_RESOLVE_EN
            r_ar       <= '0;
`endif
        end else if (i_pc_load) begin
            r_pc <= i_pc_load_value;
        end else begin
            case (r_state)
                S_FWAIT: begin
                    r_ir       <= i_mem_read_data;
                    r_instr_pc <= r_pc;
                    r_pc       <= r_pc + A'(1);
                end
                S_DECODE: begin
`ifdef INDIRECT_RESOLVE_EN
                    if (w_is_indirect) begin
                        r_ar <= r_ir[A-1:0];
                    end else begin
                        r_ea <= r_ir[A-1:0];
                    end
`else
                    r_ea <= r_ir[A-1:0];
`endif
                end
`ifdef INDIRECT_RESOLVE_EN
                S_IWAIT: r_ea <= i_mem_read_data[A-1:0];
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        o_mem_address = r_pc;
`ifdef INDIRECT_RESOLVE_EN
        if (r_state == S_INDIRECT || r_state == S_IWAIT) begin
            o_mem_address = r_ar;
        end
`endif
    end

    assign o_instr_valid  = (r_state == S_ISSUE);
    assign o_instr_ir     = r_ir;
    assign o_instr_opcode = r_ir[D-2:D-4];
    assign o_instr_i_bit  = r_ir[D-1];
    assign o_instr_ea     = r_ea;
    assign o_instr_pc     = r_instr_pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit

module tb_instruction_fetch_unit;

    localparam int A = 12;
    localparam int D = 16;

`ifdef INDIRECT_RESOLVE_EN
    localparam int     IND_LAT = 5;
    localparam [A-1:0] IND_EA  = 12'h123;
`else
    localparam int     IND_LAT = 3;
    localparam [A-1:0] IND_EA  = 12'h010;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic         fetch_enable;
    logic         pc_load;
    logic [A-1:0] pc_load_value;
    logic [A-1:0] mem_address;
    logic [D-1:0] mem_read_data;
    logic         instr_valid;
    logic         instr_ready;
    logic [D-1:0] instr_ir;
    logic [2:0]   instr_opcode;
    logic         instr_i_bit;
    logic [A-1:0] instr_ea;
    logic [A-1:0] instr_pc;

    logic [D-1:0] mem [0:4095];

    int checks   = 0;
    int errors   = 0;
    int hs_count = 0;

    always #5 clock = ~clock;

    always @(posedge clock) mem_read_data <= mem[mem_address];

    always @(posedge clock) begin
        if (!reset && instr_valid && instr_ready) hs_count++;
    end

    instruction_fetch_unit #(.A(A), .D(D)) dut (
        .i_clock         (clock),
        .i_reset         (reset),
        .i_fetch_enable  (fetch_enable),
        .i_pc_load       (pc_load),
        .i_pc_load_value (pc_load_value),
        .o_mem_address   (mem_address),
        .i_mem_read_data (mem_read_data),
        .o_instr_valid   (instr_valid),
        .i_instr_ready   (instr_ready),
        .o_instr_ir      (instr_ir),
        .o_instr_opcode  (instr_opcode),
        .o_instr_i_bit   (instr_i_bit),
        .o_instr_ea      (instr_ea),
        .o_instr_pc      (instr_pc)
    );

    // Leaves the bench at the negedge where the DUT first sits in FETCH after reset.
    task automatic apply_reset();
        @(negedge clock);
        reset   = 1'b1;
        pc_load = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Counts negedges from the current one until instr_valid; bounded.
    task automatic wait_valid(output int n);
        n = 0;
        while (instr_valid !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        mem[0]       = 16'h2005;
        fetch_enable = 1'b0;
        instr_ready  = 1'b1;
        apply_reset();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", instr_valid); end
        checks++; if (mem_address !== 12'h000) begin errors++; $display("FAIL rst_addr: got %h expected 000", mem_address); end
        checks++; if (instr_ir !== 16'h0000) begin errors++; $display("FAIL rst_ir: got %h expected 0000", instr_ir); end
        checks++; if (instr_ea !== 12'h000) begin errors++; $display("FAIL rst_ea: got %h expected 000", instr_ea); end
        checks++; if (instr_pc !== 12'h000) begin errors++; $display("FAIL rst_pc: got %h expected 000", instr_pc); end
        repeat (3) @(negedge clock);
        checks++; if (instr_valid !== 1'b0 || mem_address !== 12'h000) begin errors++; $display("FAIL idle_no_fetch: got valid=%b addr=%h expected valid=0 addr=000", instr_valid, mem_address); end
        fetch_enable = 1'b1;
        wait_valid(n);
        checks++; if (n !== 3) begin errors++; $display("FAIL direct_latency: got %0d expected 3", n); end
        checks++; if (instr_ir !== 16'h2005) begin errors++; $display("FAIL direct_ir: got %h expected 2005", instr_ir); end
        checks++; if (instr_opcode !== 3'd2) begin errors++; $display("FAIL direct_opcode: got %0d expected 2", instr_opcode); end
        checks++; if (instr_ea !== 12'h005) begin errors++; $display("FAIL direct_ea: got %h expected 005", instr_ea); end
        checks++; if (instr_pc !== 12'h000) begin errors++; $display("FAIL direct_pc: got %h expected 000", instr_pc); end
        @(negedge clock);
        checks++; if (instr_valid !== 1'b0 || mem_address !== 12'h001) begin errors++; $display("FAIL direct_next: got valid=%b addr=%h expected valid=0 addr=001", instr_valid, mem_address); end
    endtask

    task automatic test_indirect();
        int n;
        mem[0]       = 16'hA010;
        mem[12'h010] = 16'h0123;
        fetch_enable = 1'b1;
        instr_ready  = 1'b1;
        apply_reset();
        wait_valid(n);
        checks++; if (n !== IND_LAT) begin errors++; $display("FAIL ind_latency: got %0d expected %0d", n, IND_LAT); end
        checks++; if (instr_ea !== IND_EA) begin errors++; $display("FAIL ind_ea: got %h expected %h", instr_ea, IND_EA); end
        checks++; if (instr_i_bit !== 1'b1 || instr_opcode !== 3'd2) begin errors++; $display("FAIL ind_decode: got i=%b op=%0d expected i=1 op=2", instr_i_bit, instr_opcode); end
        checks++; if (instr_ir !== 16'hA010) begin errors++; $display("FAIL ind_ir: got %h expected A010", instr_ir); end
    endtask

    task automatic test_io_no_indirect();
        int n;
        mem[0]       = 16'hF800;
        fetch_enable = 1'b1;
        instr_ready  = 1'b1;
        apply_reset();
        wait_valid(n);
        checks++; if (n !== 3) begin errors++; $display("FAIL io_latency: got %0d expected 3", n); end
        checks++; if (instr_ea !== 12'h800) begin errors++; $display("FAIL io_ea: got %h expected 800", instr_ea); end
        checks++; if (instr_opcode !== 3'd7 || instr_i_bit !== 1'b1) begin errors++; $display("FAIL io_decode: got op=%0d i=%b expected op=7 i=1", instr_opcode, instr_i_bit); end
    endtask

    task automatic test_hold();
        int n;
        int h0;
        mem[0]       = 16'h2005;
        fetch_enable = 1'b1;
        instr_ready  = 1'b0;
        apply_reset();
        wait_valid(n);
        checks++; if (n !== 3) begin errors++; $display("FAIL hold_latency: got %0d expected 3", n); end
        h0 = hs_count;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            checks++;
            if (instr_valid !== 1'b1 || instr_ir !== 16'h2005 || instr_ea !== 12'h005 ||
                instr_pc !== 12'h000 || mem_address !== 12'h001) begin
                errors++;
                $display("FAIL hold_stable[%0d]: got valid=%b ir=%h ea=%h pc=%h addr=%h expected 1 2005 005 000 001",
                         c, instr_valid, instr_ir, instr_ea, instr_pc, mem_address);
            end
        end
        fetch_enable = 1'b0;
        instr_ready  = 1'b1;
        @(negedge clock);
        instr_ready = 1'b0;
        checks++; if (instr_valid !== 1'b0 || mem_address !== 12'h001) begin errors++; $display("FAIL hold_release: got valid=%b addr=%h expected valid=0 addr=001", instr_valid, mem_address); end
        repeat (3) @(negedge clock);
        checks++; if (hs_count - h0 !== 1) begin errors++; $display("FAIL hold_handshakes: got %0d expected 1", hs_count - h0); end
        checks++; if (mem_address !== 12'h001) begin errors++; $display("FAIL hold_pc: got %h expected 001", mem_address); end
    endtask

    task automatic test_pc_load_fwait();
        int n;
        mem[0]       = 16'h2005;
        mem[12'hFFF] = 16'h1234;
        fetch_enable = 1'b1;
        instr_ready  = 1'b1;
        apply_reset();
        @(negedge clock);
        pc_load       = 1'b1;
        pc_load_value = 12'hFFF;
        @(negedge clock);
        pc_load = 1'b0;
        checks++; if (instr_ir !== 16'h0000) begin errors++; $display("FAIL load_ir_kept: got %h expected 0000", instr_ir); end
        checks++; if (instr_valid !== 1'b0 || mem_address !== 12'hFFF) begin errors++; $display("FAIL load_refetch: got valid=%b addr=%h expected valid=0 addr=FFF", instr_valid, mem_address); end
        wait_valid(n);
        checks++; if (n !== 3) begin errors++; $display("FAIL load_latency: got %0d expected 3", n); end
        checks++; if (instr_ir !== 16'h1234 || instr_pc !== 12'hFFF || instr_ea !== 12'h234) begin errors++; $display("FAIL load_instr: got ir=%h pc=%h ea=%h expected 1234 FFF 234", instr_ir, instr_pc, instr_ea); end
        checks++; if (mem_address !== 12'h000) begin errors++; $display("FAIL load_wrap: got %h expected 000", mem_address); end
    endtask

    task automatic test_back_to_back();
        int n;
        int h0;
        mem[0]       = 16'h2005;
        mem[12'h020] = 16'h3007;
        fetch_enable = 1'b1;
        instr_ready  = 1'b0;
        apply_reset();
        wait_valid(n);
        h0            = hs_count;
        pc_load       = 1'b1;
        pc_load_value = 12'h020;
        instr_ready   = 1'b1;
        @(negedge clock);
        pc_load     = 1'b0;
        instr_ready = 1'b0;
        checks++; if (hs_count - h0 !== 1) begin errors++; $display("FAIL b2b_handshake: got %0d expected 1", hs_count - h0); end
        checks++; if (instr_valid !== 1'b0 || mem_address !== 12'h020) begin errors++; $display("FAIL b2b_redirect: got valid=%b addr=%h expected valid=0 addr=020", instr_valid, mem_address); end
        wait_valid(n);
        checks++; if (n !== 3) begin errors++; $display("FAIL b2b_latency: got %0d expected 3", n); end
        checks++; if (instr_ir !== 16'h3007 || instr_pc !== 12'h020 || instr_ea !== 12'h007 || instr_opcode !== 3'd3) begin errors++; $display("FAIL b2b_instr: got ir=%h pc=%h ea=%h op=%0d expected 3007 020 007 3", instr_ir, instr_pc, instr_ea, instr_opcode); end
    endtask

    task automatic test_reset_midread();
        int n;
        mem[0]       = 16'hA010;
        mem[12'h010] = 16'h0123;
        fetch_enable = 1'b1;
        instr_ready  = 1'b1;
        apply_reset();
        repeat (4) @(negedge clock);
        reset         = 1'b1;
        pc_load       = 1'b1;
        pc_load_value = 12'h055;
        @(negedge clock);
        reset   = 1'b0;
        pc_load = 1'b0;
        checks++; if (instr_valid !== 1'b0 || mem_address !== 12'h000) begin errors++; $display("FAIL midrst_state: got valid=%b addr=%h expected valid=0 addr=000", instr_valid, mem_address); end
        checks++; if (instr_ir !== 16'h0000 || instr_ea !== 12'h000 || instr_pc !== 12'h000) begin errors++; $display("FAIL midrst_regs: got ir=%h ea=%h pc=%h expected 0000 000 000", instr_ir, instr_ea, instr_pc); end
        wait_valid(n);
        checks++; if (n !== IND_LAT || instr_ea !== IND_EA) begin errors++; $display("FAIL midrst_refetch: got lat=%0d ea=%h expected %0d %h", n, instr_ea, IND_LAT, IND_EA); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        reset         = 1'b1;
        fetch_enable  = 1'b0;
        pc_load       = 1'b0;
        pc_load_value = '0;
        instr_ready   = 1'b0;
        test_reset();
        test_indirect();
        test_io_no_indirect();
        test_hold();
        test_pc_load_fwait();
        test_back_to_back();
        test_reset_midread();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
